sdram_fifo_arbmod: RTL
======================

SDRAM_FIFO_ARBMOD -- requirements
Module: sdram_fifo_arbmod

Interface
REQ-001 SHALL have parameter AW, default 22, SDRAM word-address width; SDRAM ring holds 2^AW words.
REQ-002 SHALL have port CLOCK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on CLOCK rising edge.
REQ-004 SHALL have port iTagW  input  2  write-side FIFO status: [1]=full, [0]=empty.
REQ-005 SHALL have port iTagR  input  2  read-side FIFO status: [1]=full, [0]=empty.
REQ-006 SHALL have port oEnW  output  2  write-side FIFO enable: [1] tied 0, [0]=pop one word.
REQ-007 SHALL have port oEnR  output  2  read-side FIFO enable: [1]=push one word, [0] tied 0.
REQ-008 SHALL have port oCall  output  2  SDRAM request: [1]=write one word, [0]=read one word.
REQ-009 SHALL have port iDone  input  1  one-cycle pulse from SDRAM controller completing the current call.
REQ-010 SHALL have port oAddr  output  AW  SDRAM word address for the active call.
REQ-011 SHALL have port oTag  output  2  SDRAM ring status: [1]=full, [0]=empty.

Function
REQ-012 SHALL keep write pointer WP and read pointer RP, each AW+1 bits; ring level = WP - RP modulo 2^(AW+1).
REQ-013 SHALL drive oTag[0]=1 when WP==RP, oTag[1]=1 when MSBs differ and low AW bits equal; combinational from pointers.
REQ-014 SHALL treat write as eligible when iTagW[0]==0 and oTag[1]==0.
REQ-015 SHALL treat read as eligible when oTag[0]==0 and iTagR[1]==0.
REQ-016 SHALL implement states IDLE, WCALL, WPOP, RCALL, RPUSH.
REQ-017 IDLE: if only one direction eligible, go to its CALL state; if both, grant the direction not granted last (round-robin flag LAST); if none, stay.
REQ-018 SHALL update LAST to the granted direction on every IDLE->CALL transition.
REQ-019 WCALL: oCall=2'b10, oAddr=WP[AW-1:0], held constant until iDone sampled high; then go to WPOP.
REQ-020 WPOP: exactly one cycle with oCall=0, oEnW=2'b01; WP increments by 1 at end of cycle; return to IDLE.
REQ-021 RCALL: oCall=2'b01, oAddr=RP[AW-1:0], held until iDone sampled high; then go to RPUSH.
REQ-022 RPUSH: exactly one cycle with oCall=0, oEnR=2'b10; RP increments by 1 at end of cycle; return to IDLE.
REQ-023 oCall, oEnW, oEnR, oAddr SHALL be registered; oEnW/oEnR are 0 in every state other than WPOP/RPUSH.
REQ-024 Minimum per-word latency: IDLE decision to oCall high 1 cycle; iDone to pop/push 1 cycle; pop/push to next oCall 2 cycles (through IDLE).
REQ-025 iDone SHALL be ignored in IDLE, WPOP, RPUSH.
REQ-026 Pointers SHALL wrap naturally at 2^(AW+1); oAddr wraps from 2^AW-1 to 0.
REQ-027 Eligibility SHALL be evaluated only in IDLE; status changes during a CALL do not abort it.
REQ-028 oCall[1] and oCall[0] SHALL never be high simultaneously.

Reset
REQ-029 RESET high SHALL, at the next edge, force state IDLE, WP=RP=0, LAST=read (write wins first tie), oCall=0, oEnW=0, oEnR=0, oAddr=0, from any state including mid-CALL.
REQ-030 After reset oTag SHALL read 2'b01.
REQ-031 An iDone arriving in the reset cycle SHALL be discarded; no pop/push and no pointer change.

Verification
REQ-032 Single write: iTagW=00, iTagR=00, ring empty -> oCall=10 with oAddr=0 next cycle; iDone after 5 cycles -> one-cycle oEnW=01, WP=1, oTag=00.
REQ-033 Tie arbitration: after reset, ring holds 1 word, iTagW=00, iTagR=00 -> grants alternate W,R,W,R; oAddr sequence per direction increments by 1.
REQ-034 Ring full: AW=4, write 16 words with iTagR=10 (read FIFO full) -> oTag=10, no further oCall; release iTagR=00 -> read at oAddr=0 issued.
REQ-035 Wrap: AW=4, 40 interleaved write/read words -> oAddr wraps 15->0, oTag never asserts both bits, level never exceeds 16.
REQ-036 Reset mid-call: RESET during WCALL before iDone, iDone pulse same cycle -> outputs zero, WP=0, no oEnW pulse, oTag=01.
REQ-037 Idle hold: iTagW=01, ring empty for 100 cycles -> oCall, oEnW, oEnR stay 0; stray iDone pulses cause no pointer change.

Source files
------------

// File: rtl/sdram_fifo_arbmod_if.sv
// Bus bundle between the FIFO/SDRAM arbiter and its surroundings:
// write-side FIFO status/enable, read-side FIFO status/enable, SDRAM call/done/address
// and the SDRAM ring status.
interface sdram_fifo_arbmod_if #(
  parameter int unsigned AW = 22
);

  logic [1:0]    iTagW;
  logic [1:0]    iTagR;
  logic [1:0]    oEnW;
  logic [1:0]    oEnR;
  logic [1:0]    oCall;
  logic          iDone;
  logic [AW-1:0] oAddr;
  logic [1:0]    oTag;

  // Arbiter side
  modport master (
    input  iTagW,
    input  iTagR,
    input  iDone,
    output oEnW,
    output oEnR,
    output oCall,
    output oAddr,
    output oTag
  );

  // FIFO/SDRAM-controller side
  modport slave (
    output iTagW,
    output iTagR,
    output iDone,
    input  oEnW,
    input  oEnR,
    input  oCall,
    input  oAddr,
    input  oTag
  );

endinterface

// File: rtl/sdram_fifo_arbmod.sv
// Arbiter that moves words from a write-side FIFO into an SDRAM ring buffer and
// from the ring back out into a read-side FIFO, one word per SDRAM call.
// Ties between the two directions are broken round-robin.
module sdram_fifo_arbmod #(
  parameter int unsigned AW = 22
) (
  input  logic                CLOCK,
  input  logic                RESET,
  sdram_fifo_arbmod_if.master bus
);

  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WCALL = 3'd1,
    WPOP  = 3'd2,
    RCALL = 3'd3,
    RPUSH = 3'd4
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [PW-1:0] wp;
  logic [PW-1:0] wpNext;
  logic [PW-1:0] rp;
  logic [PW-1:0] rpNext;
  logic          lastWrite;
  logic          lastWriteNext;
  logic [1:0]    callReg;
  logic [1:0]    callNext;
  logic [1:0]    enWReg;
  logic [1:0]    enWNext;
  logic [1:0]    enRReg;
  logic [1:0]    enRNext;
  logic [AW-1:0] addrReg;
  logic [AW-1:0] addrNext;

  logic ringEmpty;
  logic ringFull;
  logic wElig;
  logic rElig;
  logic unusedTags;

  // Ring status straight from the pointers; the extra MSB separates full from empty
  assign ringEmpty = (wp == rp);
  assign ringFull  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  // Write needs a non-empty source FIFO and ring space; read needs ring data and sink space
  assign wElig = !bus.iTagW[0] && !ringFull;
  assign rElig = !ringEmpty && !bus.iTagR[1];

  // Write-FIFO full and read-FIFO empty flags play no part in arbitration
  assign unusedTags = ^{bus.iTagW[1], bus.iTagR[0]};

  assign bus.oCall = callReg;
  assign bus.oEnW  = enWReg;
  assign bus.oEnR  = enRReg;
  assign bus.oAddr = addrReg;
  assign bus.oTag  = {ringFull, ringEmpty};

  // State, pointers, round-robin flag and registered outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      lastWrite <= 1'b0;
      callReg   <= 2'b00;
      enWReg    <= 2'b00;
      enRReg    <= 2'b00;
      addrReg   <= '0;
    end else begin
      state     <= stateNext;
      wp        <= wpNext;
      rp        <= rpNext;
      lastWrite <= lastWriteNext;
      callReg   <= callNext;
      enWReg    <= enWNext;
      enRReg    <= enRNext;
      addrReg   <= addrNext;
    end
  end

  // Next state plus next values of the registered outputs; outputs idle at zero
  always_comb begin
    stateNext     = state;
    wpNext        = wp;
    rpNext        = rp;
    lastWriteNext = lastWrite;
    callNext      = 2'b00;
    enWNext       = 2'b00;
    enRNext       = 2'b00;
    addrNext      = '0;

    case (state)
      IDLE: begin
        if (wElig && (!rElig || !lastWrite)) begin
          stateNext     = WCALL;
          lastWriteNext = 1'b1;
          callNext      = 2'b10;
          addrNext      = wp[AW-1:0];
        end else if (rElig) begin
          stateNext     = RCALL;
          lastWriteNext = 1'b0;
          callNext      = 2'b01;
          addrNext      = rp[AW-1:0];
        end
      end

      WCALL: begin
        if (bus.iDone) begin
          stateNext = WPOP;
          enWNext   = 2'b01;
        end else begin
          callNext = 2'b10;
          addrNext = wp[AW-1:0];
        end
      end

      WPOP: begin
        wpNext    = wp + PW'(1);
        stateNext = IDLE;
      end

      RCALL: begin
        if (bus.iDone) begin
          stateNext = RPUSH;
          enRNext   = 2'b10;
        end else begin
          callNext = 2'b01;
          addrNext = rp[AW-1:0];
        end
      end

      RPUSH: begin
        rpNext    = rp + PW'(1);
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule
